ps2_frame_deserializer: RTL and testbench

Parametrised successor to the keyboard-path serial deserializer. Consumes pre-sampled PS/2-style serial bits: the upstream edge detector strobes sample_ready once per device-clock falling edge. Checks each frame's start, parity and stop bits and enforces an inter-bit timeout. Buffers good words in a small show-ahead FIFO with a valid/ready handshake toward the scan-code decoder.

---
 rtl/ps2_frame_deserializer_pkg.sv | 20 ++
 rtl/ps2_sync_fifo.sv | 63 ++++++
 rtl/ps2_frame_deserializer.sv | 175 +++++++++++++++++
 tb/tb_ps2_frame_deserializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_frame_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 frame deserializer:
//   - 2-bit FSM state encoding (IDLE / DATA / PARITY / STOP)
//   - default inter-bit timeout in clk cycles
//   - PS/2 line levels of the start and stop bits
// ---------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int DEF_TIMEOUT_CYC = 200000;

   localparam logic PS2_START = 1'b0;
   localparam logic PS2_STOP  = 1'b1;

endpackage

// File: rtl/ps2_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps2_sync_fifo
// Single-clock show-ahead FIFO. The head word is visible on o_rdata whenever
// the FIFO is not empty (0 when empty). A push while full is accepted only
// when a pop happens in the same cycle; otherwise it is ignored.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (empties the FIFO)
//   i_push/i_wdata write request and word
//   i_pop          remove head (ignored when empty)
//   o_rdata        head word
//   o_full/o_empty occupancy flags
// ---------------------------------------------------------------------------
module ps2_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   // When full, the slot being popped this cycle is the one written.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_frame_deserializer.sv
// ---------------------------------------------------------------------------
// ps2_frame_deserializer
// Assembles PS/2-style frames (start, DATA_W data bits LSB first, optional
// parity, stop) from pre-sampled bits, checks them, enforces an inter-bit
// timeout and queues good words in a show-ahead FIFO.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   sample_ready   strobe: serial_data valid this cycle
//   serial_data    sampled line level
//   data_ready     consumer accepts FIFO head
//   data_valid     FIFO not empty
//   data_out       FIFO head
//   parity_err     1-cycle pulse, parity mismatch (frame dropped)
//   frame_err      1-cycle pulse, bad stop bit or timeout (frame dropped)
//   overrun        1-cycle pulse, good word dropped on full FIFO
//   busy           FSM not IDLE
// ---------------------------------------------------------------------------
module ps2_frame_deserializer
   import ps2_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int PARITY_EN   = 1,
   parameter int PARITY_ODD  = 1,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_ready,
   input  logic              serial_data,
   input  logic              data_ready,
   output logic              data_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int TC_W  = $clog2(TIMEOUT_CYC);

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_par_ok;
   logic [TC_W-1:0]   r_tcnt;

   logic              r_parity_err;
   logic              r_frame_err;
   logic              r_overrun;
   logic              r_busy;

   logic              w_timeout;
   logic              w_last_bit;
   logic              w_par_calc;
   logic              w_frame_evt;
   logic              w_parity_evt;
   logic              w_push;
   logic              w_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;

   // A sample arriving on the expiry cycle takes precedence over the timeout.
   assign w_timeout  = (r_state != ST_IDLE) && !sample_ready &&
                       (r_tcnt == TC_W'(TIMEOUT_CYC - 1));
   assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));
   assign w_par_calc = ^{r_shift, serial_data};
   assign w_pop      = ~w_fifo_empty & data_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      if (w_timeout) begin
         w_next_state = ST_IDLE;
      end else if (sample_ready) begin
         case (r_state)
            ST_IDLE:   if (serial_data == PS2_START) w_next_state = ST_DATA;
            ST_DATA:   if (w_last_bit)
                          w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: w_next_state = ST_STOP;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs (frame events) ----------------
   always_comb begin
      w_frame_evt  = 1'b0;
      w_parity_evt = 1'b0;
      w_push       = 1'b0;
      if (w_timeout) begin
         w_frame_evt = 1'b1;
      end else if (sample_ready && r_state == ST_STOP) begin
         if (serial_data != PS2_STOP) w_frame_evt  = 1'b1;
         else if (!r_par_ok)          w_parity_evt = 1'b1;
         else                         w_push       = 1'b1;
      end
   end

   // ---------------- datapath: shift, bit count, parity, timeout ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_ok  <= 1'b1;
         r_tcnt    <= '0;
      end else begin
         if (sample_ready || r_state == ST_IDLE || w_timeout) r_tcnt <= '0;
         else                                                 r_tcnt <= r_tcnt + 1'b1;

         if (sample_ready) begin
            case (r_state)
               ST_IDLE: begin
                  // Without a parity bit the frame is always parity-clean.
                  r_bit_cnt <= '0;
                  r_shift   <= '0;
                  r_par_ok  <= 1'b1;
               end
               ST_DATA: begin
                  // Right shift: after DATA_W bits the first bit sits at the LSB.
                  r_shift   <= {serial_data, r_shift[DATA_W-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               ST_PARITY: r_par_ok <= (PARITY_ODD != 0) ? w_par_calc : ~w_par_calc;
               default: ;
            endcase
         end
      end
   end

   // ---------------- registered status pulses ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_parity_err <= w_parity_evt;
         r_frame_err  <= w_frame_evt;
         r_overrun    <= w_push & w_fifo_full & ~w_pop;
         // Registered from the next state so busy tracks the current state.
         r_busy       <= (w_next_state != ST_IDLE);
      end
   end

   ps2_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_wdata (r_shift),
      .i_pop   (w_pop),
      .o_rdata (data_out),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign data_valid = ~w_fifo_empty;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

endmodule

// File: tb/tb_ps2_frame_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ps2_frame_deserializer
// Directed bench: 8-bit odd-parity instance (timeout 50, depth 4) plus a
// 9-bit no-parity instance. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ps2_frame_deserializer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_ready = 1'b0;
   logic       serial_data = 1'b1;
   logic       data_ready = 1'b0;
   logic       data_valid;
   logic [7:0] data_out;
   logic       parity_err, frame_err, overrun, busy;

   logic       s9_ready = 1'b0;
   logic       s9_data = 1'b1;
   logic       d9_ready = 1'b0;
   logic       d9_valid;
   logic [8:0] d9_out;
   logic       p9_err, f9_err, o9_run, b9_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ps2_frame_deserializer #(
      .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .TIMEOUT_CYC(50), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sample_ready(sample_ready),
      .serial_data(serial_data), .data_ready(data_ready),
      .data_valid(data_valid), .data_out(data_out), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   ps2_frame_deserializer #(
      .DATA_W(9), .PARITY_EN(0), .PARITY_ODD(1), .TIMEOUT_CYC(50), .FIFO_DEPTH(4)
   ) dut9 (
      .clk(clk), .reset_n(reset_n), .sample_ready(s9_ready),
      .serial_data(s9_data), .data_ready(d9_ready),
      .data_valid(d9_valid), .data_out(d9_out), .parity_err(p9_err),
      .frame_err(f9_err), .overrun(o9_run), .busy(b9_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b);
      sample_ready = 1'b1;
      serial_data  = b;
      tick();
      sample_ready = 1'b0;
      serial_data  = 1'b1;
   endtask

   // Full 8-bit frame with one idle cycle between samples. Returns in the cycle
   // right after the stop sample.
   task automatic send_frame(input logic [7:0] d, input logic pflip,
                             input logic stopb, input logic pop_stop);
      send_bit(1'b0); tick();
      for (int i = 0; i < 8; i++) begin send_bit(d[i]); tick(); end
      send_bit(~(^d) ^ pflip); tick();
      if (pop_stop) data_ready = 1'b1;
      send_bit(stopb);
      if (pop_stop) data_ready = 1'b0;
   endtask

   task automatic send_bit9(input logic b);
      s9_ready = 1'b1;
      s9_data  = b;
      tick();
      s9_ready = 1'b0;
      s9_data  = 1'b1;
   endtask

   task automatic drain_expect(input string tag, input logic [7:0] exp);
      @(negedge clk);
      chk({tag, "_valid"}, data_valid, 1);
      chk({tag, "_data"}, data_out, exp);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      repeat (3) tick();
      @(negedge clk);
      chk("rst_valid", data_valid, 0);
      chk("rst_data",  data_out, 0);
      chk("rst_perr",  parity_err, 0);
      chk("rst_ferr",  frame_err, 0);
      chk("rst_ovr",   overrun, 0);
      chk("rst_busy",  busy, 0);
      chk("rst9_valid", d9_valid, 0);
      chk("rst9_busy",  b9_busy, 0);
      reset_n = 1'b1;
      tick(); tick();

      // ---- 1: good frame 0x1C ----
      data_ready = 1'b1;
      send_bit(1'b0);
      @(negedge clk); chk("t1_busy_start", busy, 1);
      tick();
      for (int i = 0; i < 8; i++) begin send_bit(8'h1C >> i); tick(); end
      send_bit(1'b0); tick();   // odd parity of 0x1C (three ones) -> 0
      @(negedge clk); chk("t1_valid_pre", data_valid, 0);
      tick();
      send_bit(1'b1);
      @(negedge clk);
      chk("t1_valid", data_valid, 1);
      chk("t1_data",  data_out, 8'h1C);
      chk("t1_perr",  parity_err, 0);
      chk("t1_ferr",  frame_err, 0);
      chk("t1_busy",  busy, 0);
      tick();
      @(negedge clk);
      chk("t1_valid_fall", data_valid, 0);
      data_ready = 1'b0;

      // ---- 2: parity error, then stop error with bad parity ----
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("t2_perr", parity_err, 1);
      chk("t2_ferr0", frame_err, 0);
      chk("t2_valid", data_valid, 0);
      tick();
      @(negedge clk); chk("t2_perr_pulse", parity_err, 0);
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t2_ferr", frame_err, 1);
      chk("t2_perr_masked", parity_err, 0);
      chk("t2_valid2", data_valid, 0);
      tick();

      // ---- 3: timeout after start + 3 data bits ----
      send_bit(1'b0); tick();
      send_bit(1'b1); tick();
      send_bit(1'b0); tick();
      send_bit(1'b1);
      repeat (49) tick();
      @(negedge clk);
      chk("t3_ferr_early", frame_err, 0);
      chk("t3_busy_early", busy, 1);
      tick();
      @(negedge clk);
      chk("t3_ferr", frame_err, 1);
      chk("t3_busy", busy, 0);
      tick();
      @(negedge clk); chk("t3_ferr_pulse", frame_err, 0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t3_valid", data_valid, 1);
      chk("t3_data",  data_out, 8'hF0);
      chk("t3_ferr_after", frame_err, 0);
      data_ready = 1'b1; tick(); data_ready = 1'b0;

      // ---- 4: overrun ----
      for (int k = 1; k <= 4; k++) begin
         send_frame(8'(k), 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         chk("t4_no_ovr", overrun, 0);
      end
      send_frame(8'h05, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_ovr", overrun, 1);
      chk("t4_head", data_out, 8'h01);
      tick();
      @(negedge clk); chk("t4_ovr_pulse", overrun, 0);
      drain_expect("t4_d1", 8'h01);
      drain_expect("t4_d2", 8'h02);
      drain_expect("t4_d3", 8'h03);
      drain_expect("t4_d4", 8'h04);
      @(negedge clk); chk("t4_empty", data_valid, 0);
      tick();

      // ---- 5: full push with same-cycle pop ----
      for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 1'b0, 1'b1, 1'b0);
      send_frame(8'h15, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_no_ovr", overrun, 0);
      drain_expect("t5_d2", 8'h12);
      drain_expect("t5_d3", 8'h13);
      drain_expect("t5_d4", 8'h14);
      drain_expect("t5_d5", 8'h15);
      @(negedge clk); chk("t5_empty", data_valid, 0);
      tick();

      // ---- 6: reset mid-frame with two words queued ----
      send_frame(8'h21, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      send_bit(1'b0); tick();
      for (int i = 0; i < 4; i++) begin
         send_bit(8'hA5 >> i);
         if (i < 3) tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("t6_valid", data_valid, 0);
      chk("t6_data",  data_out, 0);
      chk("t6_busy",  busy, 0);
      chk("t6_ferr",  frame_err, 0);
      send_bit(1'b1);
      @(negedge clk);
      chk("t6_idle_busy", busy, 0);
      tick();
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_new_valid", data_valid, 1);
      chk("t6_new_data",  data_out, 8'h33);
      data_ready = 1'b1; tick(); data_ready = 1'b0;
      @(negedge clk); chk("t6_empty", data_valid, 0);

      // ---- 7: 9-bit frame without parity ----
      send_bit9(1'b0); tick();
      for (int i = 0; i < 9; i++) begin send_bit9(9'h1A5 >> i); tick(); end
      @(negedge clk); chk("t7_valid_pre", d9_valid, 0);
      send_bit9(1'b1);
      @(negedge clk);
      chk("t7_valid", d9_valid, 1);
      chk("t7_data",  d9_out, 9'h1A5);
      chk("t7_perr",  p9_err, 0);
      chk("t7_ferr",  f9_err, 0);
      chk("t7_busy",  b9_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
